// File: rtl/ntsc_pixel_packer.sv
// Crops synchronised NTSC pixel strobes to an active window, packs them into memory
// words (optionally mirrored) and issues ZBT writes through a 2-entry buffer.
module ntsc_pixel_packer #(
  parameter int unsigned PIX_W        = 18,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned DATA_W       = 36,
  parameter int unsigned H_ACTIVE     = 720,
  parameter int unsigned V_SKIP       = 12,
  parameter int unsigned V_ACTIVE     = 240,
  parameter int unsigned COL_W        = 10,
  parameter int unsigned ROW_W        = 8,
  parameter int unsigned WCOL_W       = 9,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned MIRROR       = 1,
  parameter int unsigned INTERLACED   = 1,
  parameter int unsigned DOUBLE_BUF   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              line_start,
  input  logic              field_start,
  input  logic              field_id,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              disp_buf,
  output logic              frame_done,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int unsigned RR_W    = $clog2(V_SKIP + V_ACTIVE + 1);
  localparam int unsigned LOG_PPW = $clog2(PIX_PER_WORD);
  localparam int unsigned LANE_W  = (PIX_PER_WORD > 1) ? LOG_PPW : 1;
  localparam int unsigned ROW_SH  = WCOL_W + INTERLACED;
  localparam int unsigned BUF_SH  = ROW_SH + ROW_W;

  localparam logic [RR_W-1:0]   ROW_LO    = RR_W'(V_SKIP);
  localparam logic [RR_W-1:0]   ROW_HI    = RR_W'(V_SKIP + V_ACTIVE);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_ACTIVE);
  localparam logic [WCOL_W-1:0] WORDS_M1  = WCOL_W'(H_ACTIVE / PIX_PER_WORD - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);

  if (ADDR_W != DOUBLE_BUF + ROW_W + INTERLACED + WCOL_W) begin : g_bad_addr_w
    $error("ADDR_W must equal DOUBLE_BUF+ROW_W+INTERLACED+WCOL_W");
  end
  if (DATA_W < PIX_W * PIX_PER_WORD) begin : g_bad_data_w
    $error("DATA_W too narrow for PIX_W*PIX_PER_WORD");
  end
  if (H_ACTIVE >= (1 << COL_W)) begin : g_bad_col_w
    $error("COL_W too narrow for H_ACTIVE");
  end

  logic [RR_W-1:0]   row_raw, row_eff;
  logic [COL_W-1:0]  col, col_eff;
  logic [LANE_W-1:0] lane, lane_eff;
  logic              field, field_eff, wbuf, wbuf_eff;
  logic              boundary, swap, accept, word_done;
  logic [PIX_W-1:0]  pix_q [PIX_PER_WORD];
  logic [ROW_W-1:0]  row_q, cur_row, first_row;
  logic [WCOL_W-1:0] wcol_q, idx, cur_wcol, first_wcol;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] word_data;

  logic [ADDR_W-1:0] fa [2];
  logic [DATA_W-1:0] fd [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              pop, push, drop;

  // The *_eff values are the coordinates a pixel strobe sees this cycle, so a
  // pixel coincident with line_start/field_start lands at the start of the new line.
  always_comb begin
    boundary  = line_start | field_start;
    swap      = field_start & ((INTERLACED != 0) ? ~field_id : 1'b1);
    row_eff   = row_raw;
    if (field_start)                   row_eff = '0;
    else if (line_start && row_raw != '1) row_eff = row_raw + 1'b1;
    col_eff   = boundary ? '0 : col;
    lane_eff  = boundary ? '0 : lane;
    field_eff = field_start ? field_id : field;
    wbuf_eff  = swap ? ~wbuf : wbuf;

    accept    = pix_valid && (row_eff >= ROW_LO) && (row_eff < ROW_HI) && (col_eff < COL_MAX);
    word_done = accept && (lane_eff == LANE_LAST);

    idx        = WCOL_W'(col_eff >> LOG_PPW);
    cur_wcol   = (MIRROR != 0) ? WORDS_M1 - idx : idx;
    cur_row    = ROW_W'(row_eff - ROW_LO);
    first_wcol = (lane_eff == '0) ? cur_wcol : wcol_q;
    first_row  = (lane_eff == '0) ? cur_row  : row_q;

    // Mirroring reverses lane placement so pixels stay spatially ordered in the word.
    word_data = '0;
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      word_data[((MIRROR != 0) ? k : PIX_PER_WORD - 1 - k) * PIX_W +: PIX_W] =
        (LANE_W'(k) == lane_eff) ? pix_data : pix_q[k];
    end

    word_addr = ADDR_W'(first_wcol) | (ADDR_W'(first_row) << ROW_SH);
    if (INTERLACED != 0) word_addr = word_addr | (ADDR_W'(field_eff) << WCOL_W);
    if (DOUBLE_BUF != 0) word_addr = word_addr | (ADDR_W'(wbuf_eff) << BUF_SH);

    wr_valid = (count != 2'd0);
    wr_addr  = fa[rd_ptr];
    wr_data  = fd[rd_ptr];
    pop      = wr_valid && wr_ready;
    push     = word_done && ((count != 2'd2) || pop);
    drop     = word_done && (count == 2'd2) && !pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_raw <= '0;
      col     <= '0;
      lane    <= '0;
      field   <= 1'b0;
      row_q   <= '0;
      wcol_q  <= '0;
      for (int unsigned i = 0; i < PIX_PER_WORD; i++) pix_q[i] <= '0;
    end else begin
      row_raw <= row_eff;
      field   <= field_eff;
      col     <= (pix_valid && col_eff != COL_MAX) ? col_eff + 1'b1 : col_eff;
      if (accept) begin
        lane            <= word_done ? '0 : lane_eff + 1'b1;
        pix_q[lane_eff] <= pix_data;
        if (lane_eff == '0) begin
          row_q  <= cur_row;
          wcol_q <= cur_wcol;
        end
      end else begin
        lane <= lane_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbuf       <= 1'b0;
      disp_buf   <= (DOUBLE_BUF != 0);
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= swap;
      if (swap) begin
        wbuf     <= ~wbuf;
        disp_buf <= (DOUBLE_BUF != 0) ? wbuf : 1'b0;
      end
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        fa[i] <= '0;
        fd[i] <= '0;
      end
    end else begin
      if (push) begin
        fa[wr_ptr] <= word_addr;
        fd[wr_ptr] <= word_data;
        wr_ptr     <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ntsc_pixel_packer.md
Name: ntsc_pixel_packer

Overview:
- Generalised successor to the NTSC-to-ZBT path. Takes clk-domain pixel strobes from the synchroniser and crops to a programmable active window.
- Packs PIX_PER_WORD pixels per memory word, with optional horizontal mirroring that keeps in-word pixel order spatially correct.
- Issues writes to the ZBT arbiter over a valid/ready handshake with a 2-entry buffer, and manages double-buffered frame selection for the display reader.

Parameters:
PIX_W, 18, bits per pixel
PIX_PER_WORD, 2, pixels per memory word (power of 2, >=1)
DATA_W, 36, memory word width; must be >= PIX_W*PIX_PER_WORD; unused MSBs written 0
H_ACTIVE, 720, active pixels per line (multiple of PIX_PER_WORD)
V_SKIP, 12, leading lines per field discarded (sync/VBI)
V_ACTIVE, 240, stored lines per field
COL_W, 10, raw column counter width
ROW_W, 8, stored-row address field width
WCOL_W, 9, word-column address field width
ADDR_W, 19, address width; must equal DOUBLE_BUF+ROW_W+INTERLACED+WCOL_W (elaboration error otherwise)
MIRROR, 1, 1 = mirror horizontally
INTERLACED, 1, 1 = field bit in address, frame = two fields
DOUBLE_BUF, 1, 1 = buffer bit in address MSB

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_valid  in  1  one-cycle strobe, pix_data valid
pix_data  in  PIX_W  pixel value
line_start  in  1  one-cycle pulse at start of each line
field_start  in  1  one-cycle pulse at start of each field
field_id  in  1  field parity, sampled on field_start
wr_valid  out  1  write request valid
wr_ready  in  1  arbiter accepts when wr_valid & wr_ready
wr_addr  out  ADDR_W  {buf, row, field, word_col}; absent fields omitted per params
wr_data  out  DATA_W  packed pixels
disp_buf  out  1  buffer holding last completed frame
frame_done  out  1  one-cycle pulse when write buffer swaps
overflow  out  1  sticky: word dropped because buffer full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, disp_buf=1, frame_done=0, overflow=0. Internal: wbuf=0, row_raw=0, col=0, lane=0, field=0, buffer empty.
- row_raw:
  - field_start: clear to 0 and latch field=field_id.
  - Else line_start: increment, saturating at all-ones.
- col:
  - Cleared on line_start or field_start.
  - Incremented by each pix_valid, saturating at H_ACTIVE.
  - If pix_valid and line_start coincide, the pixel is column 0 of the new line.
- Pixel accepted iff pix_valid & V_SKIP <= row_raw < V_SKIP+V_ACTIVE & col < H_ACTIVE. Stored row = row_raw - V_SKIP.
- Packing:
  - Accepted pixel enters lane `lane`; the first pixel of a word goes in the most-significant lane.
  - When lane==PIX_PER_WORD-1, the word completes and lane returns to 0.
  - Word column = col_of_first_pixel / PIX_PER_WORD.
  - MIRROR=1: word column = H_ACTIVE/PIX_PER_WORD-1-idx, and lane order is reversed, so the rightmost camera pixel lands at word 0, MS lane.
  - Address is computed from the first pixel's coordinates; no off-by-one-word skew is permitted.
- Partial word when line_start or field_start arrives: discarded, lane cleared, no write.
- Output buffer (2 entries, FIFO order):
  - Completed word enqueued at cycle N, where N is the strobe of the last pixel. wr_valid rises at N+1 if the buffer was empty.
  - wr_addr/wr_data stable while wr_valid & !wr_ready.
  - Enqueue and dequeue in the same cycle are allowed when full.
  - Enqueue when full with no dequeue: word dropped, overflow=1.
  - overflow clears only on clr_overflow or reset; a set on the same cycle as clr_overflow wins.
- Buffer swap:
  - INTERLACED=1: on field_start with field_id=0.
  - INTERLACED=0: on every field_start.
  - On swap: disp_buf<=wbuf, wbuf<=~wbuf, frame_done pulses next cycle.
  - The first field_start after reset counts as a swap.
  - DOUBLE_BUF=0: no buf address bit; disp_buf stays 0 and frame_done still pulses.
- Words already buffered keep their captured address across a swap.
- Reset mid-operation: everything returns to reset values immediately; pending words are lost.

Test Plan:
- Default params, field_start(field_id=1), 12 line_starts, then a line of 720 strobes with pix_data=index, wr_ready=1 -> 360 writes. First write: addr {buf=0, row=0, field=1, word=359}, data {18'd1, 18'd0}. Last write: word=0, data {18'd719, 18'd718}.
- MIRROR=0, same stimulus -> first write word=0, data {18'd0, 18'd1}.
- wr_ready=0 for 3 completed words -> 2 held in order, third dropped, overflow=1. clr_overflow -> overflow=0.
- Line of 5 accepted pixels then line_start -> 2 writes, 5th pixel discarded, next line begins at lane 0.
- Sequence field_start(1), field_start(0), field_start(1), field_start(0) -> frame_done pulses after each field_id=0 start. disp_buf reads 1, then 0, then 1.
- Assert reset_n low mid-line with wr_valid=1 -> wr_valid=0 and overflow=0 asynchronously. Next line starts at col 0.
